// File: rtl/alu_clean_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_clean_pkg                                              |
// | Desc    : Opcode encodings and default width for the golden ALU.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package alu_clean_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

endpackage : alu_clean_pkg
`default_nettype wire

// File: rtl/alu_clean_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_clean_core                                             |
// | Desc    : Combinational ADD/SUB/AND/OR datapath; flag terms are      |
// |           produced only when ALU_CLEAN_FLAGS_EN is defined.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module alu_clean_core
  import alu_clean_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
`ifdef ALU_CLEAN_FLAGS_EN
  output logic             carry,
  output logic             zero,
  output logic             neg,
`endif
  output logic [WIDTH-1:0] next_result
);

`ifdef ALU_CLEAN_FLAGS_EN
  // One extra bit holds the ADD carry-out / SUB borrow.
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum       = {1'b0, A} + {1'b0, B};
    w_diff      = {1'b0, A} - {1'b0, B};
    next_result = '0;
    carry       = 1'b0;
    case (op)
      OP_ADD: begin
        next_result = w_sum[WIDTH-1:0];
        carry       = w_sum[WIDTH];
      end
      OP_SUB: begin
        next_result = w_diff[WIDTH-1:0];
        carry       = w_diff[WIDTH];
      end
      OP_AND: next_result = A & B;
      OP_OR:  next_result = A | B;
      default: next_result = '0;
    endcase
  end

  assign zero = (next_result == '0);
  assign neg  = next_result[WIDTH-1];
`else
  always_comb begin
    next_result = '0;
    case (op)
      OP_ADD:  next_result = A + B;
      OP_SUB:  next_result = A - B;
      OP_AND:  next_result = A & B;
      OP_OR:   next_result = A | B;
      default: next_result = '0;
    endcase
  end
`endif

endmodule : alu_clean_core
`default_nettype wire

// File: rtl/alu_clean.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_clean                                                  |
// | Desc    : Golden 4-bit ALU with one-cycle registered result. Define  |
// |           ALU_CLEAN_FLAGS_EN to add registered carry/zero/neg.       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module alu_clean
  import alu_clean_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
`ifdef ALU_CLEAN_FLAGS_EN
  output logic             carry,
  output logic             zero,
  output logic             neg,
`endif
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] w_next_result;
  logic [WIDTH-1:0] r_result;

`ifdef ALU_CLEAN_FLAGS_EN
  logic w_carry;
  logic w_zero;
  logic w_neg;
  logic r_carry;
  logic r_zero;
  logic r_neg;
`endif

  // Trojan variants swap only this instance; the register stage stays fixed.
  alu_clean_core #(
    .WIDTH       (WIDTH)
  ) u_core (
    .A           (A),
    .B           (B),
    .op          (op),
`ifdef ALU_CLEAN_FLAGS_EN
    .carry       (w_carry),
    .zero        (w_zero),
    .neg         (w_neg),
`endif
    .next_result (w_next_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else begin
      r_result <= w_next_result;
    end
  end

  assign result = r_result;

`ifdef ALU_CLEAN_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_carry <= w_carry;
      r_zero  <= w_zero;
      r_neg   <= w_neg;
    end
  end

  assign carry = r_carry;
  assign zero  = r_zero;
  assign neg   = r_neg;
`endif

endmodule : alu_clean
`default_nettype wire

// File: tb/tb_alu_clean.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_alu_clean                                               |
// | Desc    : Self-checking bench for alu_clean against an arithmetic    |
// |           reference; flag checks follow ALU_CLEAN_FLAGS_EN.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_alu_clean;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic [1:0] op = '0;
  logic [3:0] result;
`ifdef ALU_CLEAN_FLAGS_EN
  logic       carry;
  logic       zero;
  logic       neg;
`endif

  int n_vec = 0;
  int n_err = 0;

  alu_clean #(
    .WIDTH  (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .op     (op),
`ifdef ALU_CLEAN_FLAGS_EN
    .carry  (carry),
    .zero   (zero),
    .neg    (neg),
`endif
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic modulo 16.
  function automatic int ref_result(input int o, input int a, input int b);
    case (o)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic int ref_carry(input int o, input int a, input int b);
    if (o == 0) return (a + b > 15) ? 1 : 0;
    if (o == 1) return (a < b) ? 1 : 0;
    return 0;
  endfunction

  task automatic step_check(input string tag, input int o, input int a, input int b);
    int exp_r;
    op = 2'(o);
    A  = 4'(a);
    B  = 4'(b);
    exp_r = ref_result(o, a, b);
    @(posedge clk);
    #1;
    check(tag, 32'(result), 32'(exp_r));
`ifdef ALU_CLEAN_FLAGS_EN
    check({tag, ".carry"}, 32'(carry), 32'(ref_carry(o, a, b)));
    check({tag, ".zero"},  32'(zero),  (exp_r == 0) ? 32'd1 : 32'd0);
    check({tag, ".neg"},   32'(neg),   (exp_r >= 8) ? 32'd1 : 32'd0);
`endif
  endtask

  initial begin
    // Reset held while the clock runs: result stays 0.
    A = 4'd7; B = 4'd3; op = 2'b00;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 32'(result), 32'd0);
`ifdef ALU_CLEAN_FLAGS_EN
      check("reset_hold.flags", {29'd0, carry, zero, neg}, 32'd0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    step_check("reset_release", 0, 7, 3);

    step_check("add_wrap", 0, 15, 1);
    step_check("sub_wrap", 1, 3, 5);
    step_check("sub_zero", 1, 9, 9);
    step_check("and", 2, 12, 10);
    step_check("or", 3, 12, 10);
    step_check("sub_0m1", 1, 0, 1);

    // Asynchronous reset pulse between edges clears result immediately.
    step_check("pre_async", 0, 6, 6);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", 32'(result), 32'd0);
    #1 rst_n = 1'b1;
    #1;
    check("async_hold", 32'(result), 32'd0);
    step_check("post_async", 0, 6, 6);

    // Inputs wiggled mid-cycle must not leak into result.
    op = 2'b11; A = 4'd1; B = 4'd2;
    #3 A = 4'd9;
    #1;
    check("mid_cycle_stable", 32'(result), 32'd12);
    step_check("mid_cycle_last", 3, 9, 2);

    for (int o = 0; o < 4; o++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          step_check("sweep", o, a, b);

    for (int i = 0; i < 200; i++)
      step_check("random", int'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
                 int'($urandom_range(15, 0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_alu_clean
`default_nettype wire
